// File: rtl/seg_pkg.sv
// Shared constants, converter state encoding and helpers for the 7-segment
// display driver and its sequential binary-to-BCD converter.
package seg_pkg;

  localparam int BCD_W = 12;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // {dp,g,f,e,d,c,b,a}, active-low, common anode
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    digit_code = (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
  endfunction

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [BCD_W+7:0] dabble_step(input logic [BCD_W+7:0] s);
    logic [BCD_W+7:0] t;
    t = s;
    for (int n = 0; n < BCD_W / 4; n++) begin
      if (t[8+4*n +: 4] >= 4'd5) t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
    end
    dabble_step = {t[BCD_W+6:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: re-converts whenever the sampled input
// differs from the last converted value and publishes the BCD result atomically.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       num_in,
  output logic [BCD_W-1:0] bcd,
  output logic             upd_pulse
);

  logic [7:0]       num_q;
  logic [7:0]       last_val;
  logic [7:0]       load_val;
  logic             first_flag;
  logic [BCD_W+7:0] shifter;
  logic [3:0]       cnt;
  logic             start;
  conv_state_t      state;
  conv_state_t      state_next;

  // NOTE: num_q has no reset so it keeps sampling the live count while rst is
  // held; the forced first conversion after release then sees the real value.
  always_ff @(posedge clk) begin
    num_q <= num_in;
  end

  assign start = first_flag || (num_q != last_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == 4'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shifter    <= '0;
      cnt        <= '0;
      load_val   <= '0;
      last_val   <= '0;
      first_flag <= 1'b1;
      bcd        <= '0;
      upd_pulse  <= 1'b0;
    end else begin
      upd_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shifter  <= {{BCD_W{1'b0}}, num_q};
            cnt      <= '0;
            load_val <= num_q;
          end
        end
        SHIFT: begin
          shifter <= dabble_step(shifter);
          cnt     <= cnt + 4'd1;
        end
        DONE: begin
          // Only place bcd changes, so the display never sees a partial result.
          bcd        <= shifter[BCD_W+7:8];
          last_val   <= load_val;
          first_flag <= 1'b0;
          upd_pulse  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// Time-multiplexed common-anode 7-segment driver fed by a sequential BCD
// converter: leading-zero blanking, overflow dashes and forced blank.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        num_in,
  input  logic              blank,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] dig_sel,
  output logic              upd_pulse
);

  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [BCD_W-1:0]  bcd;
  logic [3:0]        hundreds;
  logic [3:0]        tens;
  logic [3:0]        units;
  logic [PS_W-1:0]   ps;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [7:0]        glyph;
  logic [DIGITS-1:0] sel_next;

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .rst       (rst),
    .num_in    (num_in),
    .bcd       (bcd),
    .upd_pulse (upd_pulse)
  );

  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign units    = bcd[3:0];

  always_comb begin
    idx_next = idx;
    if (ps == PS_LAST) idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  end

  // Glyph and enable are computed for the index that becomes active on this
  // edge, so seg and dig_sel always switch together.
  always_comb begin
    glyph = SEG_BLANK;
    if (blank) begin
      glyph = SEG_BLANK;
    end else if (DIGITS == 2 && hundreds != 4'd0) begin
      glyph = SEG_DASH;
    end else if (idx_next == IDX_W'(0)) begin
      glyph = digit_code(units);
    end else if (idx_next == IDX_W'(1)) begin
      glyph = (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : digit_code(tens);
    end else begin
      glyph = (hundreds == 4'd0) ? SEG_BLANK : digit_code(hundreds);
    end
  end

  always_comb begin
    sel_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      sel_next[i] = blank || (idx_next != IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps      <= '0;
      idx     <= '0;
      seg     <= SEG_BLANK;
      dig_sel <= '1;
    end else begin
      ps      <= (ps == PS_LAST) ? '0 : ps + 1'b1;
      idx     <= idx_next;
      seg     <= glyph;
      dig_sel <= sel_next;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench: a 2-digit and a 3-digit driver share stimulus; display
// contents are compared against a decimal-arithmetic model of the glyph rules.
module tb_seg_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       blank;
  logic [7:0] num_in;
  logic [7:0] seg2, seg3;
  logic [1:0] ds2;
  logic [2:0] ds3;
  logic       upd2, upd3;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] CODE [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef struct {
    int          num;
    logic [15:0] e2;   // {tens slot, units slot}
    logic [23:0] e3;   // {hundreds, tens, units}
  } vec_t;

  always #5 clk = ~clk;

  seg_display_driver #(.DIGITS(2), .SCAN_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .num_in(num_in), .blank(blank),
    .seg(seg2), .dig_sel(ds2), .upd_pulse(upd2)
  );

  seg_display_driver #(.DIGITS(3), .SCAN_DIV(4)) dut3 (
    .clk(clk), .rst(rst), .num_in(num_in), .blank(blank),
    .seg(seg3), .dig_sel(ds3), .upd_pulse(upd3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_glyph(input int n, input int idx, input int digits);
    int h = n / 100;
    int t = (n / 10) % 10;
    int u = n % 10;
    if (digits == 2 && h != 0) return 8'hBF;
    if (idx == 0) return CODE[u];
    if (idx == 1) return (h == 0 && t == 0) ? 8'hFF : CODE[t];
    return (h == 0) ? 8'hFF : CODE[h];
  endfunction

  task automatic wait_upd(input int max_cyc, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (upd2) begin
        cyc = k;
        break;
      end
    end
  endtask

  // Watch a few full scan rounds and record the glyph shown in each slot.
  task automatic scan(output logic [15:0] s2p, output logic [23:0] s3p, output int bad);
    s2p = '0;
    s3p = '0;
    bad = 0;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      case (ds2)
        2'b10:   s2p[7:0]  = seg2;
        2'b01:   s2p[15:8] = seg2;
        default: bad++;
      endcase
      case (ds3)
        3'b110:  s3p[7:0]   = seg3;
        3'b101:  s3p[15:8]  = seg3;
        3'b011:  s3p[23:16] = seg3;
        default: bad++;
      endcase
    end
  endtask

  task automatic verify_display(input string name, input int n);
    logic [15:0] s2p;
    logic [23:0] s3p;
    int bad;
    scan(s2p, s3p, bad);
    check({name, "_dsel"}, bad, 0);
    check({name, "_d2"}, s2p, {model_glyph(n, 1, 2), model_glyph(n, 0, 2)});
    check({name, "_d3"}, s3p, {model_glyph(n, 2, 3), model_glyph(n, 1, 3), model_glyph(n, 0, 3)});
  endtask

  initial begin
    vec_t vecs[6];
    int   cyc;
    int   last;
    int   a, b, i0, idx;

    vecs[0] = '{5,   16'hFF92, 24'hFFFF92};
    vecs[1] = '{0,   16'hFFC0, 24'hFFFFC0};
    vecs[2] = '{255, 16'hBFBF, 24'hA49292};
    vecs[3] = '{100, 16'hBFBF, 24'hF9C0C0};
    vecs[4] = '{10,  16'hF9C0, 24'hFFF9C0};
    vecs[5] = '{29,  16'hA490, 24'hFFA490};

    rst    = 1'b1;
    blank  = 1'b0;
    num_in = 8'd29;
    repeat (3) @(negedge clk);
    check("rst_seg2", seg2, 8'hFF);
    check("rst_dsel2", ds2, 2'b11);
    check("rst_upd2", upd2, 0);
    check("rst_seg3", seg3, 8'hFF);
    check("rst_dsel3", ds3, 3'b111);

    // First conversion after release is forced even though the value is "unchanged".
    rst = 1'b0;
    wait_upd(30, cyc);
    check("first_upd_latency", (cyc >= 9 && cyc <= 12), 1);
    check("first_upd3", upd3, 1);
    @(negedge clk);
    check("upd_one_cycle", upd2, 0);
    verify_display("n29", 29);

    // Exact latency: captured at E, pulse visible only after E+10.
    num_in = 8'd28;
    repeat (10) @(negedge clk);
    check("lat_e9", upd2, 0);
    @(negedge clk);
    check("lat_e10", upd2, 1);
    verify_display("n28", 28);

    for (int i = 0; i < 6; i++) begin
      logic [15:0] s2p;
      logic [23:0] s3p;
      int bad;
      num_in = vecs[i].num[7:0];
      wait_upd(30, cyc);
      check($sformatf("tab%0d_upd", i), cyc > 0, 1);
      scan(s2p, s3p, bad);
      check($sformatf("tab%0d_dsel", i), bad, 0);
      check($sformatf("tab%0d_d2", i), s2p, vecs[i].e2);
      check($sformatf("tab%0d_d3", i), s3p, vecs[i].e3);
    end
    last = 29;

    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(0, 255));
      num_in = n[7:0];
      if (n != last) begin
        wait_upd(30, cyc);
        check($sformatf("rnd%0d_upd", r), cyc > 0, 1);
      end
      verify_display($sformatf("rnd%0d_n%0d", r, n), n);
      last = n;
    end

    // Value changes mid-conversion: first conversion completes, then the new one.
    a = (last + 37) % 256;
    b = (a + 1) % 256;
    num_in = a[7:0];
    repeat (3) @(negedge clk);
    num_in = b[7:0];
    wait_upd(30, cyc);
    check("mid_first_upd", cyc > 0, 1);
    wait_upd(30, cyc);
    check("mid_second_upd", cyc > 0, 1);
    verify_display("mid_final", b);
    last = b;

    // Blank mid-scan: outputs dark on the next edge while the scan keeps moving.
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      logic [1:0] prev;
      prev = ds2;
      @(negedge clk);
      if (ds2 != prev) begin
        cyc = 1;
        break;
      end
    end
    check("blank_scan_seen", cyc, 1);
    i0 = (ds2 == 2'b10) ? 0 : 1;
    blank = 1'b1;
    @(negedge clk);
    check("blank_seg2", seg2, 8'hFF);
    check("blank_dsel2", ds2, 2'b11);
    check("blank_dsel3", ds3, 3'b111);
    repeat (4) @(negedge clk);
    check("blank_hold_seg2", seg2, 8'hFF);
    blank = 1'b0;
    @(negedge clk);
    idx = (i0 + 1) % 2;
    check("unblank_dsel2", ds2, (idx == 0) ? 2'b10 : 2'b01);
    check("unblank_seg2", seg2, model_glyph(last, idx, 2));

    // Reset during SHIFT: outputs clear asynchronously, conversion redone after release.
    a = (last + 100) % 256;
    num_in = a[7:0];
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_shift_seg2", seg2, 8'hFF);
    check("rst_shift_dsel2", ds2, 2'b11);
    check("rst_shift_upd2", upd2, 0);
    check("rst_shift_dsel3", ds3, 3'b111);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_upd(30, cyc);
    check("rst_shift_reconv", cyc > 0, 1);
    verify_display("rst_shift_final", a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
